// File: rtl/mrfm_pkg.sv
// ---------------------------------------------------------------------------
// mrfm_pkg
// Shared definitions for the channel packer: packer FSM state type, config
// word field positions, the default settings-bus address of the config
// register, and the numchan clamp helper.
// ---------------------------------------------------------------------------
package mrfm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pk_state_t;

    localparam int NUMCH_LSB   = 0;
    localparam int NUMCH_W     = 4;
    localparam int ENABLE_BIT  = 8;
    localparam int TESTPAT_BIT = 9;

    // Settings-bus address of the RX mux / packer config register.
    localparam logic [6:0] SR_ADDR_DEFAULT = 7'd30;

    // Raw numchan 0 means one channel; anything above the channel count
    // saturates to the channel count.
    function automatic int clamp_numchan(input logic [NUMCH_W-1:0] raw, input int num_ch);
        if (raw == '0) begin
            return 1;
        end
        if (int'(raw) > num_ch) begin
            return num_ch;
        end
        return int'(raw);
    endfunction

endpackage

// File: rtl/mrfm_packer_cfg.sv
// ---------------------------------------------------------------------------
// mrfm_packer_cfg
// Settings-bus decode and config register for the channel packer.
// Optional feature macro: MRFM_PACKER_TESTPAT_EN (test-pattern bit stored).
// Ports:
//   clock, reset_n        clock / async active-low reset
//   serial_strobe/addr/data  settings-bus write
//   enable                config enable bit
//   testpat               config test-pattern bit (0 when feature absent)
//   numchan_eff           clamped channel count, 1..NUM_CH
// ---------------------------------------------------------------------------
module mrfm_packer_cfg
    import mrfm_pkg::*;
#(
    parameter int         NUM_CH  = 8,
    parameter logic [6:0] SR_ADDR = SR_ADDR_DEFAULT,
    parameter int         CNT_W   = $clog2(NUM_CH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             serial_strobe,
    input  logic [6:0]       serial_addr,
    input  logic [31:0]      serial_data,
    output logic             enable,
    output logic             testpat,
    output logic [CNT_W-1:0] numchan_eff
);

    logic [NUMCH_W-1:0] r_numchan;
    logic               r_enable;
    logic               w_wr;
    logic               w_unused_data;

    assign w_wr = serial_strobe && (serial_addr == SR_ADDR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_numchan <= '0;
            r_enable  <= 1'b0;
        end else if (w_wr) begin
            r_numchan <= serial_data[NUMCH_LSB +: NUMCH_W];
            r_enable  <= serial_data[ENABLE_BIT];
        end
    end

`ifdef MRFM_PACKER_TESTPAT_EN
    logic r_testpat;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_testpat <= 1'b0;
        end else if (w_wr) begin
            r_testpat <= serial_data[TESTPAT_BIT];
        end
    end

    assign testpat       = r_testpat;
    assign w_unused_data = ^{serial_data[31:TESTPAT_BIT+1], serial_data[ENABLE_BIT-1:NUMCH_W]};
`else
    assign testpat       = 1'b0;
    assign w_unused_data = ^{serial_data[31:TESTPAT_BIT], serial_data[ENABLE_BIT-1:NUMCH_W]};
`endif

    assign enable      = r_enable;
    assign numchan_eff = CNT_W'(clamp_numchan(r_numchan, NUM_CH));

endmodule

// File: rtl/mrfm_chan_packer.sv
// ---------------------------------------------------------------------------
// mrfm_chan_packer
// Latches NUM_CH parallel WIDTH-bit samples on strobe_in and serialises the
// first numchan of them onto a valid/ready stream. Sticky overrun flags
// frames dropped because a previous frame was still pending.
// Optional feature macro: MRFM_PACKER_TESTPAT_EN (test pattern + frame counter).
//
// state | meaning
// IDLE  | no frame pending, waiting for strobe_in with enable set
// SEND  | presenting shadow[idx] on the stream
//
// Ports:
//   clock, reset_n          clock / async active-low reset
//   serial_*                settings-bus write to config register
//   strobe_in, ch_in        frame capture pulse and channel samples
//   clear_status            clears overrun
//   out_data/chan/first/valid, out_ready   sample stream
//   overrun, busy           status
// ---------------------------------------------------------------------------
module mrfm_chan_packer
    import mrfm_pkg::*;
#(
    parameter int         NUM_CH  = 8,
    parameter int         WIDTH   = 16,
    parameter logic [6:0] SR_ADDR = SR_ADDR_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      serial_strobe,
    input  logic [6:0]                serial_addr,
    input  logic [31:0]               serial_data,
    input  logic                      strobe_in,
    input  logic [NUM_CH*WIDTH-1:0]   ch_in,
    input  logic                      clear_status,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0] out_chan,
    output logic                      out_first,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(NUM_CH + 1);

    pk_state_t                    r_state;
    pk_state_t                    w_state_nxt;
    logic [NUM_CH-1:0][WIDTH-1:0] r_shadow;
    logic [IDX_W-1:0]             r_idx;
    logic [IDX_W-1:0]             r_last_idx;
    logic                         r_overrun;

    logic                         w_enable;
    logic                         w_testpat;
    logic [CNT_W-1:0]             w_numchan_eff;
    logic [IDX_W-1:0]             w_last_idx_new;
    logic                         w_xfer;
    logic                         w_end;
    logic                         w_cap;
    logic                         w_drop;
    logic [WIDTH-1:0]             w_sample;

    mrfm_packer_cfg #(
        .NUM_CH  (NUM_CH),
        .SR_ADDR (SR_ADDR),
        .CNT_W   (CNT_W)
    ) u_cfg (
        .clock         (clock),
        .reset_n       (reset_n),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .enable        (w_enable),
        .testpat       (w_testpat),
        .numchan_eff   (w_numchan_eff)
    );

    // numchan_eff is at least 1, so the last index never underflows.
    assign w_last_idx_new = IDX_W'(w_numchan_eff - CNT_W'(1));

    assign w_xfer = (r_state == SEND) && out_ready;
    assign w_end  = w_xfer && (r_idx == r_last_idx);
    // A strobe landing on the final transfer starts the next frame with no bubble.
    assign w_cap  = strobe_in && w_enable && ((r_state == IDLE) || w_end);
    assign w_drop = strobe_in && (r_state == SEND) && !w_end;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_cap) w_state_nxt = SEND;
            SEND: if (w_end && !w_cap) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture, index and status registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow   <= '0;
            r_last_idx <= '0;
            r_idx      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_cap) begin
                r_shadow   <= ch_in;
                r_last_idx <= w_last_idx_new;
                r_idx      <= '0;
            end else if (w_xfer) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // A new drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_status) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef MRFM_PACKER_TESTPAT_EN
    logic             r_tp;
    logic [WIDTH-5:0] r_frame_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tp        <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_cap) begin
                r_tp <= w_testpat;
            end
            if (w_end) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_sample = r_tp ? {4'(r_idx), r_frame_cnt} : r_shadow[r_idx];
`else
    logic w_unused_tp;

    assign w_unused_tp = w_testpat;
    assign w_sample    = r_shadow[r_idx];
`endif

    // Output logic
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_first = 1'b0;
        out_data  = '0;
        out_chan  = '0;
        if (r_state == SEND) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_first = (r_idx == '0);
            out_data  = w_sample;
            out_chan  = r_idx;
        end
    end

    assign overrun = r_overrun;

endmodule

// File: tb/tb_mrfm_chan_packer.sv
// ---------------------------------------------------------------------------
// tb_mrfm_chan_packer
// Directed and randomised stimulus for mrfm_chan_packer. The reference model
// keeps a queue of samples still owed by the current frame; frame acceptance,
// drops and overrun follow from the queue length and the ready input.
// ---------------------------------------------------------------------------
module tb_mrfm_chan_packer;
    import mrfm_pkg::*;

    localparam int NUM_CH = 8;
    localparam int WIDTH  = 16;
    localparam logic [6:0] SRA = SR_ADDR_DEFAULT;

    logic                    clock;
    logic                    reset_n;
    logic                    serial_strobe;
    logic [6:0]              serial_addr;
    logic [31:0]             serial_data;
    logic                    strobe_in;
    logic [NUM_CH*WIDTH-1:0] ch_in;
    logic                    clear_status;
    logic [WIDTH-1:0]        out_data;
    logic [2:0]              out_chan;
    logic                    out_first;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overrun;
    logic                    busy;

    mrfm_chan_packer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .strobe_in     (strobe_in),
        .ch_in         (ch_in),
        .clear_status  (clear_status),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .out_first     (out_first),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overrun       (overrun),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [2:0]       c;
        logic             f;
    } smp_t;

    smp_t        q[$];
    logic        m_ov;
    logic [31:0] m_cfg;
    logic [11:0] m_frames;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        int   nc;
        int   n;
        logic tp;
        smp_t s;
        nc = int'(m_cfg[3:0]);
        n  = (nc == 0) ? 1 : ((nc > NUM_CH) ? NUM_CH : nc);
`ifdef MRFM_PACKER_TESTPAT_EN
        tp = m_cfg[9];
`else
        tp = 1'b0;
`endif
        for (int k = 0; k < n; k++) begin
            s.c = 3'(k);
            s.f = (k == 0);
            s.d = tp ? {4'(k), m_frames} : ch_in[k*WIDTH +: WIDTH];
            q.push_back(s);
        end
    endtask

    // Called at a negedge: checks current outputs, drives one cycle of inputs,
    // advances the model, and returns at the next negedge.
    task automatic step(input logic stb, input logic rdy, input logic clr,
                        input logic wr, input logic [6:0] wa, input logic [31:0] wd);
        logic xfer;
        logic fin;
        logic acc;
        logic drp;
        chk("out_valid", out_valid, q.size() > 0);
        chk("busy", busy, q.size() > 0);
        chk("overrun", overrun, m_ov);
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_chan", out_chan, q[0].c);
            chk("out_first", out_first, q[0].f);
        end
        strobe_in     = stb;
        out_ready     = rdy;
        clear_status  = clr;
        serial_strobe = wr;
        serial_addr   = wa;
        serial_data   = wd;
        xfer = (q.size() > 0) && rdy;
        fin  = xfer && (q.size() == 1);
        acc  = stb && m_cfg[8] && ((q.size() == 0) || fin);
        drp  = stb && (q.size() > 0) && !fin;
        if (xfer) void'(q.pop_front());
        if (fin) m_frames++;
        if (acc) push_frame();
        if (drp) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        if (wr && (wa == SRA)) m_cfg = wd;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cfg_wr(input logic [31:0] wd);
        step(1'b0, 1'b1, 1'b0, 1'b1, SRA, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
    endtask

    task automatic rand_ch();
        for (int k = 0; k < NUM_CH; k++) ch_in[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    task automatic model_reset();
        q.delete();
        m_ov     = 1'b0;
        m_cfg    = 32'h0;
        m_frames = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        reset_n       = 1'b0;
        serial_strobe = 1'b0;
        serial_addr   = SRA;
        serial_data   = 32'h0;
        strobe_in     = 1'b0;
        ch_in         = '0;
        clear_status  = 1'b0;
        out_ready     = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_first", out_first, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // numchan=4, ready held high, known channel values
        cfg_wr(32'h0000_0104);
        for (int k = 0; k < NUM_CH; k++) ch_in[k*WIDTH +: WIDTH] = 16'h1000 + WIDTH'(k);
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        idle(6);

        // numchan=0 -> 1 sample, numchan=15 -> 8 samples
        cfg_wr(32'h0000_0100);
        rand_ch();
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        idle(3);
        cfg_wr(32'h0000_010F);
        rand_ch();
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        idle(10);

        // numchan=2 with stalls, then a strobe while pending
        cfg_wr(32'h0000_0102);
        rand_ch();
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, SRA, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, SRA, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        rand_ch();
        step(1'b1, 1'b0, 1'b0, 1'b0, SRA, 32'h0);
        idle(4);
        step(1'b0, 1'b1, 1'b1, 1'b0, SRA, 32'h0);

        // back-to-back on the last transfer, then clear racing a drop
        rand_ch();
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        rand_ch();
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        rand_ch();
        step(1'b1, 1'b1, 1'b1, 1'b0, SRA, 32'h0);
        idle(4);

        // async reset mid-frame
        rand_ch();
        step(1'b1, 1'b0, 1'b0, 1'b0, SRA, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, SRA, 32'h0);
        chk("pre_rst_overrun", overrun, m_ov);
        chk("pre_rst_valid", out_valid, q.size() > 0);
        strobe_in = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_overrun", overrun, 0);
        chk("async_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        rand_ch();
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        idle(2);

        // test pattern: numchan=3, three frames
        cfg_wr(32'h0000_0303);
        for (int f = 0; f < 3; f++) begin
            rand_ch();
            step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
            idle(3);
        end

        // enable cleared mid-frame: frame completes, later strobes ignored
        cfg_wr(32'h0000_0108);
        rand_ch();
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, SRA, 32'h0000_0008);
        idle(8);
        rand_ch();
        step(1'b1, 1'b1, 1'b0, 1'b0, SRA, 32'h0);
        idle(2);

        // randomised traffic with occasional reconfiguration
        cfg_wr(32'h0000_0100 | 32'($urandom_range(15)));
        for (int i = 0; i < 600; i++) begin
            logic        stb;
            logic        rdy;
            logic        clr;
            logic        wr;
            logic [6:0]  wa;
            logic [31:0] wd;
            rand_ch();
            stb = ($urandom_range(3) == 0);
            rdy = ($urandom_range(3) != 0);
            clr = ($urandom_range(15) == 0);
            wr  = ($urandom_range(24) == 0);
            wa  = ($urandom_range(7) == 0) ? SRA + 7'd1 : SRA;
            wd  = {22'h0, 1'($urandom_range(1)), ($urandom_range(5) != 0), 4'h0,
                   4'($urandom_range(15))};
            step(stb, rdy, clr, wr, wa, wd);
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
